nco_sweep_controller: RTL and testbench
=======================================

# nco_sweep_controller

Sequencer for the quarter-wave NCO. It generates the NCO's `sample_clk_ce` strobe from a programmable divider and drives its `phase_increment`. Under a start/abort handshake it steps the increment through a linear frequency sweep: single, sawtooth-repeat or triangle. It sits between the register/control block and the NCO, and is the only writer of the NCO's increment.

## Interface
- `PHASE_WIDTH`, 20, width of phase increment; matches the NCO.
- `DWELL_WIDTH`, 16, width of the dwell counter, counted in sample strobes.
- `DIV_WIDTH`, 8, width of the sample-strobe divider.
- `clk` in 1: system clock.
- `arst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle sweep request, sampled only in IDLE.
- `abort` in 1: stop the sweep; honoured in any state.
- `cfg_start_inc` in `PHASE_WIDTH`: sweep start increment.
- `cfg_stop_inc` in `PHASE_WIDTH`: sweep end increment; must be ≥ start.
- `cfg_step` in `PHASE_WIDTH`: increment change per dwell; must be nonzero.
- `cfg_dwell` in `DWELL_WIDTH`: strobes per step, minus 1.
- `cfg_div` in `DIV_WIDTH`: clocks between strobes, minus 1.
- `cfg_mode` in 2: 00 single, 01 sawtooth repeat, 10 triangle repeat, 11 treated as 00.
- `sample_clk_ce` out 1: one-cycle NCO sample strobe.
- `phase_increment` out `PHASE_WIDTH`: to the NCO.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse when a sweep completes.
- `cfg_err` out 1: one-cycle pulse on rejected configuration.

## Operation
- States: IDLE, UP, DOWN.
- **Reset.** All outputs are 0, state is IDLE, and the divider and dwell counters are 0.
- **Strobe divider.**
  - The divider is free-running in every state and is not affected by `start`/`abort`.
  - It counts 0..`cfg_div`; `sample_clk_ce` is high in the cycle the count equals `cfg_div`, then the count wraps to 0.
  - `cfg_div`=0 gives a strobe every cycle.
  - `cfg_div` is read live.
- **Start from IDLE.**
  - On `start`, latch all `cfg_*` except `cfg_div`.
  - Illegal configuration is `step`==0 or `start_inc` > `stop_inc`. In that case: load `phase_increment` = `cfg_start_inc`, pulse `done` and `cfg_err`, remain in IDLE.
  - Otherwise: load `phase_increment` = `start_inc`, clear the dwell counter, set `busy`, go to UP.
- **Dwell.** The dwell counter advances on each `sample_clk_ce` while busy. It expires on the strobe at which the count equals `cfg_dwell`, then clears.
- **UP, on expiry:**
  - If inc ≠ stop: inc ← min(inc+step, stop). The compare uses a `PHASE_WIDTH`+1-bit sum, so there is no wrap-around.
  - If inc = stop and mode is single: go to IDLE, `busy` low, pulse `done`; the increment holds at stop.
  - If inc = stop and mode is sawtooth: inc ← start, stay in UP.
  - If inc = stop and mode is triangle: go to DOWN; inc ← max(stop−step, start).
- **DOWN, on expiry:**
  - If inc ≠ start: inc ← max(inc−step, start). The compare uses a `PHASE_WIDTH`+1-bit signed difference.
  - If inc = start: go to UP; inc ← min(start+step, stop).
- **Degenerate case.** start == stop is legal: the increment holds at that value, and single mode completes after one dwell.
- **Abort.**
  - In UP/DOWN: next cycle IDLE, `busy` low, `phase_increment` holds its current value, no `done`.
  - `abort` and `start` together in IDLE: abort wins; the start is ignored.
- **`start` while busy** is ignored.
- **Latched configuration.** Config changes while busy have no effect, except `cfg_div`.

## Timing
- All outputs are registered.
- `start` at edge t gives `busy`=1 and `phase_increment`=start_inc from t+1. `cfg_err`/`done` for a rejected config also appear at t+1.
- An increment update takes effect the cycle after the expiring strobe, so the NCO sees the new increment from its next strobe onward.
- Single-mode completion: `done`=1 and `busy`=0 in the same cycle, one cycle after the final expiring strobe.
- Abort latency is 1 cycle.
- `arst` mid-sweep clears everything immediately (asynchronously). The divider restarts at 0, so the first strobe after reset release occurs `cfg_div`+1 cycles after release.

## Structure
- Package `nco_ctrl_pkg`: state enum (IDLE/UP/DOWN) and mode constants (`MODE_SINGLE`, `MODE_SAW`, `MODE_TRI`).
- Sub-module `ce_divider` (parameter `DIV_WIDTH`): free-running strobe generator, reused by other sample-rate blocks.
- The FSM, dwell counter and saturating add/subtract live in the top module.

## Test plan
- **Divider.** `cfg_div`=3, no start → `sample_clk_ce` high on every 4th cycle after reset release; `phase_increment`=0, `busy`=0.
- **Single sweep.** `div`=0, `start_inc`=100, `stop_inc`=130, `step`=10, `dwell`=1, mode 00 → increments 100,110,120,130, each held 2 strobes; `done` pulses once; final value 130.
- **Triangle.** `start_inc`=0, `stop_inc`=25, `step`=10, mode 10 → sequence 0,10,20,25,15,5,0,10… with no overshoot; `busy` stays high.
- **Sawtooth and abort.** Sawtooth with `stop_inc`=`2^PHASE_WIDTH`−1, `step`=`2^(PHASE_WIDTH-1)` → saturates at max, then wraps to start. Then assert `abort` → `busy`=0 next cycle, increment held, no `done`.
- **Bad config.** `start` with `step`=0, and separately with `start_inc`=50, `stop_inc`=40 → `cfg_err` and `done` pulse at t+1; state stays IDLE; `phase_increment`=`cfg_start_inc`.
- **Reset and ignored requests.** `arst` asserted mid-dwell → all outputs 0 immediately. `start`+`abort` in the same IDLE cycle → no sweep. `start` while busy → ignored.

Source files
------------

// File: rtl/nco_ctrl_pkg.sv
// Shared types for the NCO sweep controller: FSM states, sweep mode codes and
// mode normalisation.
package nco_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_SAW    = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  // The reserved code 2'b11 behaves as a single sweep.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == MODE_SAW || mode == MODE_TRI) ? mode : MODE_SINGLE;
  endfunction

endpackage

// File: rtl/nco_sweep_controller_if.sv
// Control-side request/configuration bus and NCO-side outputs of the sweep
// controller, bundled so the register block and controller share one port.
interface nco_sweep_controller_if #(
  parameter int PHASE_WIDTH = 20,
  parameter int DWELL_WIDTH = 16,
  parameter int DIV_WIDTH   = 8
);
  logic                   start;
  logic                   abort;
  logic [PHASE_WIDTH-1:0] cfg_start_inc;
  logic [PHASE_WIDTH-1:0] cfg_stop_inc;
  logic [PHASE_WIDTH-1:0] cfg_step;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic [DIV_WIDTH-1:0]   cfg_div;
  logic [1:0]             cfg_mode;

  logic                   sample_clk_ce;
  logic [PHASE_WIDTH-1:0] phase_increment;
  logic                   busy;
  logic                   done;
  logic                   cfg_err;

  modport master (
    output start, abort, cfg_start_inc, cfg_stop_inc, cfg_step, cfg_dwell,
           cfg_div, cfg_mode,
    input  sample_clk_ce, phase_increment, busy, done, cfg_err
  );

  modport slave (
    input  start, abort, cfg_start_inc, cfg_stop_inc, cfg_step, cfg_dwell,
           cfg_div, cfg_mode,
    output sample_clk_ce, phase_increment, busy, done, cfg_err
  );
endinterface

// File: rtl/ce_divider.sv
// Free-running clock-enable generator: one registered strobe every div_i+1
// cycles, first strobe div_i+1 cycles after reset release.
module ce_divider #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 ce_o
);
  logic [DIV_WIDTH-1:0] cnt_q;
  logic                 ce_q;
  logic                 wrap;

  // >= rather than == so a live decrease of div_i cannot strand the count.
  assign wrap = (cnt_q >= div_i);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      cnt_q <= wrap ? '0 : cnt_q + DIV_WIDTH'(1);
      ce_q  <= wrap;
    end
  end

  assign ce_o = ce_q;
endmodule

// File: rtl/nco_sweep_controller.sv
// NCO sequencer: drives the sample strobe and steps the phase increment through
// a single, sawtooth or triangle linear sweep under start/abort control.
module nco_sweep_controller
  import nco_ctrl_pkg::*;
#(
  parameter int PHASE_WIDTH = 20,
  parameter int DWELL_WIDTH = 16,
  parameter int DIV_WIDTH   = 8
) (
  input logic                   clk,
  input logic                   arst,
  nco_sweep_controller_if.slave bus
);
  state_e                 state_q;
  logic [PHASE_WIDTH-1:0] inc_q, start_q, stop_q, step_q;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_len_q;
  logic [1:0]             mode_q;
  logic                   busy_q, done_q, cfg_err_q;

  logic                   ce;
  logic                   expire;
  logic                   cfg_bad;
  logic [PHASE_WIDTH:0]   up_sum, dn_diff;
  logic [PHASE_WIDTH-1:0] inc_up_d, inc_dn_d;

  ce_divider #(.DIV_WIDTH(DIV_WIDTH)) u_ce_divider (
    .clk   (clk),
    .arst  (arst),
    .div_i (bus.cfg_div),
    .ce_o  (ce)
  );

  // One extra bit on sum/difference keeps saturation exact at the range ends.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch forms.
    up_sum   = {1'b0, inc_q} + {1'b0, step_q};
    dn_diff  = {1'b0, inc_q} - {1'b0, step_q};
    inc_up_d = up_sum[PHASE_WIDTH-1:0];
    inc_dn_d = dn_diff[PHASE_WIDTH-1:0];
    if (up_sum > {1'b0, stop_q}) inc_up_d = stop_q;
    if (dn_diff[PHASE_WIDTH] || (dn_diff[PHASE_WIDTH-1:0] < start_q)) inc_dn_d = start_q;
  end

  assign expire  = ce && (dwell_q == dwell_len_q);
  assign cfg_bad = (bus.cfg_step == '0) || (bus.cfg_start_inc > bus.cfg_stop_inc);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      inc_q       <= '0;
      start_q     <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      dwell_len_q <= '0;
      mode_q      <= MODE_SINGLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (busy_q && ce) dwell_q <= expire ? '0 : dwell_q + DWELL_WIDTH'(1);

      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            inc_q       <= bus.cfg_start_inc;
            start_q     <= bus.cfg_start_inc;
            stop_q      <= bus.cfg_stop_inc;
            step_q      <= bus.cfg_step;
            dwell_len_q <= bus.cfg_dwell;
            mode_q      <= norm_mode(bus.cfg_mode);
            if (cfg_bad) begin
              done_q    <= 1'b1;
              cfg_err_q <= 1'b1;
            end else begin
              dwell_q <= '0;
              busy_q  <= 1'b1;
              state_q <= UP;
            end
          end
        end

        UP: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (expire) begin
            if (inc_q != stop_q) begin
              inc_q <= inc_up_d;
            end else begin
              case (mode_q)
                MODE_SAW: inc_q <= start_q;
                MODE_TRI: begin
                  state_q <= DOWN;
                  inc_q   <= inc_dn_d;
                end
                default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              endcase
            end
          end
        end

        DOWN: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (expire) begin
            if (inc_q != start_q) begin
              inc_q <= inc_dn_d;
            end else begin
              state_q <= UP;
              inc_q   <= inc_up_d;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sample_clk_ce   = ce;
  assign bus.phase_increment = inc_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.cfg_err         = cfg_err_q;
endmodule

// File: tb/tb_nco_sweep_controller.sv
// Randomised bench for nco_sweep_controller: expected increments come from a
// per-dwell value list built with plain integer arithmetic.
module tb_nco_sweep_controller;
  import nco_ctrl_pkg::*;

  localparam int PW = 20;
  localparam int DW = 16;
  localparam int VW = 8;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  nco_sweep_controller_if #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW), .DIV_WIDTH(VW)) bus ();

  nco_sweep_controller #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW), .DIV_WIDTH(VW)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  int     checks   = 0;
  int     failures = 0;
  longint seq[$];
  int     up_len;
  longint model_inc;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ce"}, bus.sample_clk_ce, 0);
    check({tag, "_inc"}, bus.phase_increment, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_err"}, bus.cfg_err, 0);
  endtask

  // Increment held during each successive dwell, from the sweep rules alone.
  task automatic build_seq(input longint s, input longint p, input longint st, input int md);
    longint up[$];
    longint dn[$];
    longint v;
    seq.delete();
    v = s;
    while (v < p) begin up.push_back(v); v += st; end
    up.push_back(p);
    v = p - st;
    while (v > s) begin dn.push_back(v); v -= st; end
    dn.push_back(s);
    up_len = up.size();
    foreach (up[i]) seq.push_back(up[i]);
    if (md == MODE_TRI) foreach (dn[i]) seq.push_back(dn[i]);
    while (seq.size() < 200 && (md == MODE_SAW || md == MODE_TRI)) begin
      if (md == MODE_SAW) begin
        foreach (up[i]) seq.push_back(up[i]);
      end else begin
        for (int i = 1; i < up.size(); i++) seq.push_back(up[i]);
        foreach (dn[i]) seq.push_back(dn[i]);
      end
    end
  endtask

  task automatic divider_check(input int div, input int cycles);
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      check("div_ce", bus.sample_clk_ce, (k % (div + 1) == 0) ? 1 : 0);
      check("div_inc", bus.phase_increment, 0);
      check("div_busy", bus.busy, 0);
    end
  endtask

  task automatic run_sweep(input longint s, input longint p, input longint st, input int dw,
                           input int dv, input int md, input int abort_after, input bit poke);
    bit single_m;
    bit poked;
    bit fin;
    int n;
    int idx;
    int budget;
    int stray;
    single_m = !(md == MODE_SAW || md == MODE_TRI);
    build_seq(s, p, st, md);
    @(negedge clk);
    bus.cfg_start_inc = PW'(s);
    bus.cfg_stop_inc  = PW'(p);
    bus.cfg_step      = PW'(st);
    bus.cfg_dwell     = DW'(dw);
    bus.cfg_div       = VW'(dv);
    bus.cfg_mode      = 2'(md);
    bus.start         = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_busy", bus.busy, 1);
    check("start_inc", bus.phase_increment, s);
    n = 0; idx = 0; budget = 0; stray = 0; poked = 0; fin = 0;
    while (!fin) begin
      if (bus.done || bus.cfg_err) stray++;
      if (bus.sample_clk_ce) begin
        idx = n / (dw + 1);
        check("sweep_inc", bus.phase_increment, seq[idx]);
        check("sweep_busy", bus.busy, 1);
        n++;
        if (single_m && n == up_len * (dw + 1)) begin
          @(negedge clk);
          check("done_pulse", bus.done, 1);
          check("done_busy", bus.busy, 0);
          check("done_inc", bus.phase_increment, p);
          check("done_err", bus.cfg_err, 0);
          @(negedge clk);
          check("done_once", bus.done, 0);
          check("done_idle", bus.busy, 0);
          model_inc = p;
          fin = 1;
        end else if (!single_m && n == abort_after) begin
          bus.abort = 1'b1;
          @(negedge clk);
          bus.abort = 1'b0;
          check("abort_busy", bus.busy, 0);
          check("abort_done", bus.done, 0);
          check("abort_hold", bus.phase_increment, seq[idx]);
          @(negedge clk);
          check("abort_idle", bus.busy, 0);
          check("abort_nodone", bus.done, 0);
          check("abort_hold2", bus.phase_increment, seq[idx]);
          model_inc = seq[idx];
          fin = 1;
        end
      end
      if (!fin) begin
        bus.start = 1'b0;
        if (poke && !poked && n == 1) begin
          // Restart request with scrambled config mid-sweep must change nothing.
          poked = 1;
          bus.start         = 1'b1;
          bus.cfg_start_inc = PW'($urandom);
          bus.cfg_stop_inc  = PW'($urandom);
          bus.cfg_step      = PW'($urandom);
          bus.cfg_dwell     = DW'($urandom);
          bus.cfg_mode      = 2'($urandom);
        end
        @(negedge clk);
        budget++;
        if (budget > 20000) begin
          check("sweep_timeout", 0, 1);
          fin = 1;
        end
      end
    end
    bus.start = 1'b0;
    check("stray_done", stray, 0);
  endtask

  task automatic bad_config(input longint s, input longint p, input longint st);
    @(negedge clk);
    bus.cfg_start_inc = PW'(s);
    bus.cfg_stop_inc  = PW'(p);
    bus.cfg_step      = PW'(st);
    bus.cfg_dwell     = DW'(0);
    bus.cfg_mode      = MODE_SINGLE;
    bus.start         = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("err_pulse", bus.cfg_err, 1);
    check("err_done", bus.done, 1);
    check("err_busy", bus.busy, 0);
    check("err_inc", bus.phase_increment, s);
    @(negedge clk);
    check("err_once", bus.cfg_err, 0);
    check("err_done_once", bus.done, 0);
    repeat (4) @(negedge clk);
    check("err_idle", bus.busy, 0);
    check("err_inc_hold", bus.phase_increment, s);
    model_inc = s;
  endtask

  initial begin
    arst              = 1'b1;
    bus.start         = 1'b0;
    bus.abort         = 1'b0;
    bus.cfg_start_inc = '0;
    bus.cfg_stop_inc  = '0;
    bus.cfg_step      = '0;
    bus.cfg_dwell     = '0;
    bus.cfg_div       = VW'(3);
    bus.cfg_mode      = MODE_SINGLE;
    model_inc         = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    arst = 1'b0;
    divider_check(3, 12);

    run_sweep(100, 130, 10, 1, 0, MODE_SINGLE, 0, 1);
    run_sweep(0, 25, 10, 0, 0, MODE_TRI, 30, 0);
    run_sweep(5, (longint'(1) << PW) - 1, longint'(1) << (PW - 1), 0, 1, MODE_SAW, 12, 0);
    run_sweep(70, 70, 3, 1, 1, MODE_SINGLE, 0, 0);

    bad_config(77, 90, 0);
    bad_config(50, 40, 5);

    // Simultaneous start and abort in IDLE: abort wins.
    @(negedge clk);
    bus.cfg_start_inc = PW'(300);
    bus.cfg_stop_inc  = PW'(400);
    bus.cfg_step      = PW'(10);
    bus.start         = 1'b1;
    bus.abort         = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("sa_busy", bus.busy, 0);
    check("sa_done", bus.done, 0);
    check("sa_inc", bus.phase_increment, model_inc);
    repeat (3) @(negedge clk);
    check("sa_idle", bus.busy, 0);

    for (int r = 0; r < 12; r++) begin
      longint s, p, st;
      int dw, dv, md;
      s  = $urandom_range(0, 200);
      p  = s + $urandom_range(0, 100);
      st = $urandom_range(1, 40);
      dw = $urandom_range(0, 3);
      dv = $urandom_range(0, 3);
      md = $urandom_range(0, 3);
      run_sweep(s, p, st, dw, dv, md, $urandom_range(5, 40), (r % 2) == 1);
    end

    // Asynchronous reset in the middle of a long dwell.
    @(negedge clk);
    bus.cfg_start_inc = PW'(0);
    bus.cfg_stop_inc  = PW'(1000);
    bus.cfg_step      = PW'(1);
    bus.cfg_dwell     = DW'(50);
    bus.cfg_div       = VW'(0);
    bus.cfg_mode      = MODE_SINGLE;
    bus.start         = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("rst_pre_busy", bus.busy, 1);
    repeat (5) @(negedge clk);
    arst = 1'b1;
    #1;
    check_all_zero("arst_mid");
    bus.cfg_div = VW'(3);
    repeat (2) @(negedge clk);
    arst = 1'b0;
    divider_check(3, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
